// File: rtl/zombie_wave_controller.sv
// Zombie wave sequencer: level FSM, movement tick, and per-lane spawn/position/kill bookkeeping.
// Optional RANDOM_LANE_EN: spawn lane picked from an 8-bit LFSR instead of round-robin.
module zombie_wave_controller #(
    parameter int unsigned NUM_LANES = 5,
    parameter int unsigned TICK_DIV  = 500000,
    parameter logic [9:0]  START_X   = 10'd640,
    parameter logic [9:0]  END_X     = 10'd0,
    parameter logic [7:0]  SPAWN_GAP = 8'd64,
    parameter int unsigned L1_COUNT  = 5,
    parameter int unsigned L2_COUNT  = 10,
    parameter int unsigned L3_COUNT  = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_LANES-1:0]      kill,
    output logic [NUM_LANES-1:0]      lane_active,
    output logic [10*NUM_LANES-1:0]   lane_x,
    output logic                      move_tick,
    output logic [7:0]                state,
    output logic [15:0]               zombies_killed,
    output logic                      game_lost,
    output logic                      game_won
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned LW     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [7:0] {
        S_I     = 8'h01,
        S_L1    = 8'h02,
        S_NL2   = 8'h04,
        S_L2    = 8'h08,
        S_NL3   = 8'h10,
        S_L3    = 8'h20,
        S_DONEL = 8'h40,
        S_DONEW = 8'h80
    } state_e;

    state_e                 state_q, state_d;
    logic [TICK_W-1:0]      tick_q, tick_d;
    logic                   move_tick_q, move_tick_d;
    logic [7:0]             gap_q, gap_d;
    logic [7:0]             to_spawn_q, to_spawn_d;
    logic [LW-1:0]          rr_q, rr_d;
    logic [NUM_LANES-1:0]   active_q, active_d;
    logic [9:0]             x_q [NUM_LANES];
    logic [9:0]             x_d [NUM_LANES];
    logic [15:0]            killed_q, killed_d;
    logic                   lost_q, won_q;

    logic [LW-1:0]          start_idx;
    logic [LW-1:0]          pick;
    logic                   found;
    logic [NUM_LANES-1:0]   kill_v;
    logic [3:0]             kill_cnt;
    logic [16:0]            killed_sum;
    logic [7:0]             gap_inc;
    logic                   loss;
    logic                   in_level;

`ifdef RANDOM_LANE_EN
    logic [7:0] lfsr_q;

    // Free-running Fibonacci LFSR, taps 8,6,5,4
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_comb start_idx = LW'(int'(lfsr_q[2:0]) % int'(NUM_LANES));
`else
    always_comb start_idx = (int'(rr_q) == int'(NUM_LANES) - 1) ? '0 : rr_q + LW'(1);
`endif

    // First free lane at or after start_idx, using pre-kill occupancy
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            if (!found && !active_q[LW'((int'(start_idx) + k) % int'(NUM_LANES))]) begin
                found = 1'b1;
                pick  = LW'((int'(start_idx) + k) % int'(NUM_LANES));
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        move_tick_d = 1'b0;
        gap_d       = gap_q;
        to_spawn_d  = to_spawn_q;
        rr_d        = rr_q;
        active_d    = active_q;
        x_d         = x_q;
        killed_d    = killed_q;
        kill_v      = '0;
        kill_cnt    = '0;
        killed_sum  = '0;
        gap_inc     = gap_q;
        loss        = 1'b0;
        in_level    = (state_q == S_L1) || (state_q == S_L2) || (state_q == S_L3);

        if (in_level) begin
            move_tick_d = (tick_q == TICK_W'(TICK_DIV - 1));
            tick_d      = move_tick_d ? '0 : tick_q + TICK_W'(1);

            kill_v = kill & active_q;
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                kill_cnt = kill_cnt + 4'(kill_v[i]);
            end
            killed_sum = {1'b0, killed_q} + 17'(kill_cnt);
            killed_d   = killed_sum[16] ? 16'hFFFF : killed_sum[15:0];

            // Kill takes priority over movement and the loss check in the same lane
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                if (kill_v[i]) begin
                    active_d[i] = 1'b0;
                    x_d[i]      = START_X;
                end else if (move_tick_q && active_q[i]) begin
                    x_d[i] = x_q[i] - 10'd1;
                    if ((x_q[i] - 10'd1) == END_X) loss = 1'b1;
                end
            end

            if (move_tick_q) begin
                gap_inc = (gap_q >= SPAWN_GAP) ? SPAWN_GAP : gap_q + 8'd1;
                gap_d   = gap_inc;
                if (gap_inc == SPAWN_GAP && to_spawn_q != 8'd0 && found) begin
                    active_d[pick] = 1'b1;
                    x_d[pick]      = START_X;
                    rr_d           = pick;
                    to_spawn_d     = to_spawn_q - 8'd1;
                    gap_d          = 8'd0;
                end
            end
        end

        case (state_q)
            S_I:     if (start) state_d = S_L1;
            S_NL2:   if (start) state_d = S_L2;
            S_NL3:   if (start) state_d = S_L3;
            S_L1, S_L2, S_L3: begin
                if (loss) begin
                    state_d = S_DONEL;
                end else if (to_spawn_q == 8'd0 && active_q == '0) begin
                    state_d = (state_q == S_L1) ? S_NL2 :
                              (state_q == S_L2) ? S_NL3 : S_DONEW;
                end
            end
            S_DONEL, S_DONEW: begin
                if (start) begin
                    state_d  = S_I;
                    killed_d = '0;
                    active_d = '0;
                    rr_d     = '0;
                    for (int i = 0; i < int'(NUM_LANES); i++) x_d[i] = START_X;
                end
            end
            default: state_d = S_I;
        endcase

        if (state_d != state_q) begin
            tick_d      = '0;
            move_tick_d = 1'b0;
            // Gap preset makes the first spawn land on the level's first tick
            if (state_d == S_L1 || state_d == S_L2 || state_d == S_L3) gap_d = SPAWN_GAP;
            if (state_d == S_L1) to_spawn_d = 8'(L1_COUNT);
            if (state_d == S_L2) to_spawn_d = 8'(L2_COUNT);
            if (state_d == S_L3) to_spawn_d = 8'(L3_COUNT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_I;
            tick_q      <= '0;
            move_tick_q <= 1'b0;
            gap_q       <= '0;
            to_spawn_q  <= '0;
            rr_q        <= '0;
            active_q    <= '0;
            for (int i = 0; i < int'(NUM_LANES); i++) x_q[i] <= START_X;
            killed_q    <= '0;
            lost_q      <= 1'b0;
            won_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            move_tick_q <= move_tick_d;
            gap_q       <= gap_d;
            to_spawn_q  <= to_spawn_d;
            rr_q        <= rr_d;
            active_q    <= active_d;
            x_q         <= x_d;
            killed_q    <= killed_d;
            lost_q      <= (state_d == S_DONEL);
            won_q       <= (state_d == S_DONEW);
        end
    end

    for (genvar g = 0; g < int'(NUM_LANES); g++) begin : g_lane_x
        assign lane_x[10*g +: 10] = x_q[g];
    end

    assign lane_active    = active_q;
    assign move_tick      = move_tick_q;
    assign state          = state_q;
    assign zombies_killed = killed_q;
    assign game_lost      = lost_q;
    assign game_won       = won_q;

endmodule

// File: tb/tb_zombie_wave_controller.sv
// Directed bench for zombie_wave_controller: two instances, short lanes (X=8) and long lanes (X=100).
module tb_zombie_wave_controller;

    logic        clk = 1'b0;
    logic        reset_a, reset_b;
    logic        start_a, start_b;
    logic [4:0]  kill_a, kill_b;
    logic [4:0]  act_a, act_b;
    logic [49:0] x_a, x_b;
    logic        tick_a, tick_b;
    logic [7:0]  st_a, st_b;
    logic [15:0] kc_a, kc_b;
    logic        lost_a, won_a, lost_b, won_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    zombie_wave_controller #(
        .NUM_LANES(5), .TICK_DIV(4), .START_X(10'd8), .END_X(10'd0), .SPAWN_GAP(8'd2),
        .L1_COUNT(2), .L2_COUNT(10), .L3_COUNT(15)
    ) u_dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .kill(kill_a),
        .lane_active(act_a), .lane_x(x_a), .move_tick(tick_a), .state(st_a),
        .zombies_killed(kc_a), .game_lost(lost_a), .game_won(won_a)
    );

    zombie_wave_controller #(
        .NUM_LANES(5), .TICK_DIV(4), .START_X(10'd100), .END_X(10'd0), .SPAWN_GAP(8'd2),
        .L1_COUNT(2), .L2_COUNT(10), .L3_COUNT(15)
    ) u_dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .kill(kill_b),
        .lane_active(act_b), .lane_x(x_b), .move_tick(tick_b), .state(st_b),
        .zombies_killed(kc_b), .game_lost(lost_b), .game_won(won_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] lx(input logic [49:0] v, input int lane);
        return v[10*lane +: 10];
    endfunction

    task automatic pulse_start(input int which);
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic pulse_kill(input int which, input logic [4:0] k);
        if (which == 0) kill_a = k; else kill_b = k;
        @(negedge clk);
        kill_a = '0;
        kill_b = '0;
    endtask

    // Returns at the negedge inside the next move_tick cycle
    task automatic wait_tick(input int which, input string tag);
        int n = 0;
        logic t;
        @(negedge clk);
        t = (which == 0) ? tick_a : tick_b;
        while (!t && n < 32) begin
            @(negedge clk);
            n++;
            t = (which == 0) ? tick_a : tick_b;
        end
        check(tag, 64'(t), 64'd1);
    endtask

    task automatic ticks(input int which, input int cnt, input string tag);
        for (int i = 0; i < cnt; i++) wait_tick(which, tag);
    endtask

    initial begin
        int n;
        reset_a = 1'b1; reset_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        kill_a  = '0;   kill_b  = '0;
        repeat (3) @(negedge clk);
        check("rst_state", 64'(st_a), 64'h01);
        check("rst_active", 64'(act_a), 64'h0);
        check("rst_x", 64'(x_a), 64'({5{10'd8}}));
        check("rst_kills", 64'(kc_a), 64'h0);
        check("rst_tick", 64'(tick_a), 64'h0);
        check("rst_flags", 64'({lost_a, won_a}), 64'h0);
        reset_a = 1'b0; reset_b = 1'b0;
        @(negedge clk);

        // Level entry, tick latency, first two spawns
        pulse_start(0);
        check("t1_state_l1", 64'(st_a), 64'h02);
        n = 0;
        do begin @(negedge clk); n++; end while (!tick_a && n < 20);
        check("t1_tick_latency", 64'(n), 64'd4);
        @(negedge clk);
        check("t1_spawn_lane1", 64'(act_a), 64'b00010);
        check("t1_lane1_x", 64'(lx(x_a, 1)), 64'd8);
        ticks(0, 2, "t1_tick");
        @(negedge clk);
        check("t1_spawn_lane2", 64'(act_a), 64'b00110);
        check("t1_lane1_x_after3", 64'(lx(x_a, 1)), 64'd6);
        check("t1_lane2_x", 64'(lx(x_a, 2)), 64'd8);

        // No kills: lane 1 walks to END_X and the level is lost
        for (int k = 4; k <= 9; k++) begin
            wait_tick(0, "t2_tick");
            @(negedge clk);
            check("t2_lane1_x", 64'(lx(x_a, 1)), 64'(9 - k));
        end
        check("t2_state_lost", 64'(st_a), 64'h40);
        check("t2_game_lost", 64'(lost_a), 64'd1);
        repeat (6) @(negedge clk);
        check("t2_frozen_x2", 64'(lx(x_a, 2)), 64'd2);
        check("t2_no_tick", 64'(tick_a), 64'd0);
        check("t2_kills", 64'(kc_a), 64'd0);
        pulse_start(0);
        check("t2_restart_state", 64'(st_a), 64'h01);
        check("t2_restart_kills", 64'(kc_a), 64'd0);
        check("t2_restart_active", 64'(act_a), 64'd0);
        check("t2_restart_lost", 64'(lost_a), 64'd0);

        // Double kill clears L1, then L2 entered
        pulse_start(0);
        ticks(0, 3, "t3_tick");
        @(negedge clk);
        check("t3_active_pre", 64'(act_a), 64'b00110);
        pulse_kill(0, 5'b00110);
        check("t3_kills", 64'(kc_a), 64'd2);
        check("t3_active_post", 64'(act_a), 64'd0);
        @(negedge clk);
        check("t3_state_nl2", 64'(st_a), 64'h04);
        repeat (8) @(negedge clk);
        check("t3_nl2_idle", 64'({tick_a, st_a}), 64'h004);
        pulse_start(0);
        check("t3_state_l2", 64'(st_a), 64'h08);

        // Mid-L2 asynchronous reset with three lanes occupied
        ticks(0, 5, "t6_tick");
        @(negedge clk);
        check("t6_active_pre", 64'(act_a), 64'b11001);
        #2 reset_a = 1'b1;
        #1;
        check("t6_async_state", 64'(st_a), 64'h01);
        check("t6_async_active", 64'(act_a), 64'd0);
        check("t6_async_x", 64'(x_a), 64'({5{10'd8}}));
        check("t6_async_kills", 64'(kc_a), 64'd0);
        check("t6_async_tick", 64'(tick_a), 64'd0);
        @(negedge clk);
        reset_a = 1'b0;
        @(negedge clk);

        // Kill beats loss on lane 1; kill on idle lane 3 ignored
        pulse_start(0);
        ticks(0, 9, "t4_tick");
        check("t4_lane1_x_pre", 64'(lx(x_a, 1)), 64'd1);
        pulse_kill(0, 5'b01010);
        check("t4_state_l1", 64'(st_a), 64'h02);
        check("t4_kills", 64'(kc_a), 64'd1);
        check("t4_active", 64'(act_a), 64'b00100);
        check("t4_lane1_x", 64'(lx(x_a, 1)), 64'd8);
        check("t4_lane2_x", 64'(lx(x_a, 2)), 64'd2);
        @(negedge clk);
        check("t4_no_loss", 64'({lost_a, st_a}), 64'h002);
        pulse_kill(0, 5'b00100);
        check("t4_kills2", 64'(kc_a), 64'd2);
        @(negedge clk);
        check("t4_state_nl2", 64'(st_a), 64'h04);

        // Full lanes defer spawning until a kill frees one
        pulse_start(1);
        ticks(1, 3, "t5_l1_tick");
        @(negedge clk);
        pulse_kill(1, 5'b00110);
        @(negedge clk);
        check("t5_state_nl2", 64'(st_b), 64'h04);
        pulse_start(1);
        check("t5_state_l2", 64'(st_b), 64'h08);
        ticks(1, 9, "t5_tick");
        @(negedge clk);
        check("t5_all_active", 64'(act_b), 64'b11111);
        ticks(1, 2, "t5_tick");
        @(negedge clk);
        check("t5_deferred", 64'(act_b), 64'b11111);
        check("t5_lane3_x", 64'(lx(x_b, 3)), 64'd90);
        pulse_kill(1, 5'b00001);
        check("t5_kill_active", 64'(act_b), 64'b11110);
        check("t5_kill_x0", 64'(lx(x_b, 0)), 64'd100);
        check("t5_kills", 64'(kc_b), 64'd3);
        @(negedge clk);
        check("t5_no_same_cycle", 64'(act_b), 64'b11110);
        wait_tick(1, "t5_retry_tick");
        @(negedge clk);
        check("t5_respawn", 64'(act_b), 64'b11111);
        check("t5_respawn_x0", 64'(lx(x_b, 0)), 64'd100);
        check("t5_lane3_x2", 64'(lx(x_b, 3)), 64'd89);
        check("t5_state", 64'({lost_b, won_b, st_b}), 64'h008);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
